test_key_ctrl: RTL and testbench
================================

TEST_KEY_CTRL -- requirements
Module: test_key_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles (10 ms at 100 MHz) to accept a key level.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50_000_000, cycles from accepted press to first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10_000_000, cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have ports: clk in 1, system clock; rst_n in 1, reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have test_enable in 1, auto-test mode active.
REQ-006 SHALL have key_mode, key_step, key_dn_dn, key_dn_up, key_up_dn, key_up_up, key_default, each in 1, raw asynchronous board keys, active-low.
REQ-007 SHALL have adjust_mode out 3, 0=IDLE 1=FREQ 2=AMP 3=DUTY 4=THD.
REQ-008 SHALL have step_mode out 2, 0=fine 1=mid 2=coarse.
REQ-009 SHALL have btn_limit_dn_dn, btn_limit_dn_up, btn_limit_up_dn, btn_limit_up_up, btn_reset_default, each out 1, single-cycle active-high command pulses.

Function
REQ-010 SHALL pass every raw key through its own two-flop synchronizer.
REQ-011 SHALL keep one debounced level per key, released after reset; per-key counter increments while synchronized level differs from debounced level, clears on any match, and flips the debounced level when it reaches DEBOUNCE_CYCLES.
REQ-012 SHALL define a press event as a debounced released->pressed transition; release events generate no pulse.
REQ-013 SHALL advance adjust_mode IDLE->FREQ->AMP->DUTY->THD->IDLE on each key_mode press event while test_enable=1.
REQ-014 SHALL advance step_mode 0->1->2->0 on each key_step press event regardless of test_enable; value 3 never output.
REQ-015 SHALL force adjust_mode to IDLE on the cycle after test_enable falls and hold it IDLE while test_enable=0; step_mode is retained.
REQ-016 SHALL emit all command pulses from registers, asserted exactly DEBOUNCE_CYCLES+3 cycles after the first clk edge sampling the stable pressed raw level.
REQ-017 SHALL qualify command pulses: none asserted when test_enable=0, adjust_mode=IDLE, or a key_mode press event occurs in the same cycle (that limit press is discarded, not deferred).
REQ-018 SHALL emit btn_reset_default once per key_default press event, never repeated.
REQ-019 SHALL run one shared auto-repeat FSM for the four limit keys, states R_IDLE, R_DELAY, R_REPEAT, with a registered active-key index and a counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-020 R_IDLE: on a limit-key press event emit that key's pulse, latch it active, clear counter, go R_DELAY.
REQ-021 R_DELAY: at counter=REPEAT_DELAY-1 emit active key pulse, clear counter, go R_REPEAT; R_REPEAT: at counter=REPEAT_PERIOD-1 emit pulse, clear counter, stay.
REQ-022 SHALL, on a press event of a different limit key in R_DELAY/R_REPEAT, emit the new key's pulse, make it active, clear counter, go R_DELAY; previously held key stops repeating.
REQ-023 SHALL, on simultaneous press events of several limit keys, pulse each in that cycle and make the lowest-numbered (dn_dn<dn_up<up_dn<up_up) active.
REQ-024 SHALL return to R_IDLE when active key is debounced-released, test_enable=0, or adjust_mode becomes IDLE; no pulse on that cycle.
REQ-025 SHALL assert at most one pulse per output per cycle; repeat pulses obey REQ-017 qualification.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously drive adjust_mode=0, step_mode=0, all pulse outputs 0, all debounced levels released, all counters 0, synchronizers to released (1), FSM R_IDLE.
REQ-027 SHALL, on reset mid-hold, require a fresh debounced press after release-detect before any pulse (a key held through reset debounces as a new press, one pulse).

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-028 test_enable=1, key_mode low 3 cycles then high -> no change; held 10 cycles -> adjust_mode 0->1 once, no pulses.
REQ-029 adjust_mode=FREQ, key_up_up held 40 cycles -> btn_limit_up_up at t=7, 27, 32, 37, 42; none after release.
REQ-030 key_dn_up held, key_dn_dn pressed at t=30 -> dn_dn pulse, dn_up repeats stop, dn_dn repeats at +20, +25.
REQ-031 key_step pressed 4 times with test_enable=0 -> step_mode 1,2,0,1; no command pulses; adjust_mode stays 0.
REQ-032 adjust_mode=THD, test_enable dropped during R_REPEAT -> adjust_mode=0 next cycle, pulses cease, FSM R_IDLE.
REQ-033 rst_n pulsed low mid-repeat with key held -> outputs 0 immediately; one fresh pulse only after adjust_mode re-entered non-IDLE and key re-debounced.

Source files
------------

// File: rtl/test_key_ctrl.sv
// Front-panel key controller for the auto-test mode: synchronizes and debounces the
// board keys, tracks adjust/step modes and emits qualified, auto-repeating command pulses.
module test_key_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       test_enable,
   input  logic       key_mode,
   input  logic       key_step,
   input  logic       key_dn_dn,
   input  logic       key_dn_up,
   input  logic       key_up_dn,
   input  logic       key_up_up,
   input  logic       key_default,
   output logic [2:0] adjust_mode,
   output logic [1:0] step_mode,
   output logic       btn_limit_dn_dn,
   output logic       btn_limit_dn_up,
   output logic       btn_limit_up_dn,
   output logic       btn_limit_up_up,
   output logic       btn_reset_default
);

   localparam int unsigned NKEY = 7;
   localparam int unsigned DCW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RCW  = $clog2(RMAX + 1);

   // Key vector bit positions; limit keys occupy 2..5 in priority order
   localparam int unsigned K_MODE = 0;
   localparam int unsigned K_STEP = 1;
   localparam int unsigned K_DEF  = 6;

   localparam logic [2:0] M_IDLE = 3'd0;
   localparam logic [2:0] M_THD  = 3'd4;

   localparam logic [1:0] R_IDLE   = 2'd0;
   localparam logic [1:0] R_DELAY  = 2'd1;
   localparam logic [1:0] R_REPEAT = 2'd2;

   logic [NKEY-1:0] raw;
   logic [NKEY-1:0] sync1_q, sync2_q;
   logic [NKEY-1:0] deb_q, deb_d;
   logic [NKEY-1:0] deb_prev_q;
   logic [NKEY-1:0] ev_q, ev_d;
   logic [DCW-1:0]  dcnt_q [NKEY];
   logic [DCW-1:0]  dcnt_d [NKEY];

   logic [2:0]      adjust_mode_q, adjust_mode_d;
   logic [1:0]      step_mode_q, step_mode_d;
   logic [1:0]      rstate_q, rstate_d;
   logic [1:0]      act_q, act_d;
   logic [RCW-1:0]  rcnt_q, rcnt_d;
   logic [3:0]      lim_pulse_q, lim_pulse_d;
   logic            def_pulse_q, def_pulse_d;

   logic            qual;
   logic [3:0]      lim_ev;
   logic [3:0]      lim_deb;
   logic [3:0]      act_onehot;

   assign raw = {key_default, key_up_up, key_up_dn, key_dn_up, key_dn_dn, key_step, key_mode};

   // Per-key debounce: count consecutive mismatching cycles, flip level on the last one
   always_comb begin
      deb_d = deb_q;
      for (int k = 0; k < NKEY; k++) begin
         dcnt_d[k] = '0;
         if (sync2_q[k] != deb_q[k]) begin
            if (dcnt_q[k] == DCW'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[k] = sync2_q[k];
            end else begin
               dcnt_d[k] = dcnt_q[k] + DCW'(1);
            end
         end
      end
      ev_d = deb_prev_q & ~deb_q;
   end

   // Mode registers: adjust_mode cycles only in test mode, step_mode always
   always_comb begin
      adjust_mode_d = adjust_mode_q;
      step_mode_d   = step_mode_q;
      if (!test_enable) begin
         adjust_mode_d = M_IDLE;
      end else if (ev_q[K_MODE]) begin
         adjust_mode_d = (adjust_mode_q == M_THD) ? M_IDLE : adjust_mode_q + 3'd1;
      end
      if (ev_q[K_STEP]) begin
         step_mode_d = (step_mode_q == 2'd2) ? 2'd0 : step_mode_q + 2'd1;
      end
   end

   // A mode press in the same cycle swallows any command pulse
   assign qual       = test_enable && (adjust_mode_q != M_IDLE) && !ev_q[K_MODE];
   assign lim_ev     = qual ? ev_q[5:2] : 4'b0000;
   assign lim_deb    = deb_q[5:2];
   assign act_onehot = 4'b0001 << act_q;

   // Shared auto-repeat FSM: new presses win, then abort/release, then repeat timing
   always_comb begin
      rstate_d    = rstate_q;
      act_d       = act_q;
      rcnt_d      = rcnt_q;
      lim_pulse_d = 4'b0000;
      def_pulse_d = qual && ev_q[K_DEF];
      if (!test_enable || (adjust_mode_q == M_IDLE)) begin
         rstate_d = R_IDLE;
         rcnt_d   = '0;
      end else if (lim_ev != 4'b0000) begin
         lim_pulse_d = lim_ev;
         rcnt_d      = '0;
         rstate_d    = R_DELAY;
         if (lim_ev[0])      act_d = 2'd0;
         else if (lim_ev[1]) act_d = 2'd1;
         else if (lim_ev[2]) act_d = 2'd2;
         else                act_d = 2'd3;
      end else if (rstate_q != R_IDLE) begin
         if (lim_deb[act_q]) begin
            rstate_d = R_IDLE;
            rcnt_d   = '0;
         end else begin
            case (rstate_q)
               R_DELAY: begin
                  if (rcnt_q == RCW'(REPEAT_DELAY - 1)) begin
                     lim_pulse_d = qual ? act_onehot : 4'b0000;
                     rcnt_d      = '0;
                     rstate_d    = R_REPEAT;
                  end else begin
                     rcnt_d = rcnt_q + RCW'(1);
                  end
               end
               R_REPEAT: begin
                  if (rcnt_q == RCW'(REPEAT_PERIOD - 1)) begin
                     lim_pulse_d = qual ? act_onehot : 4'b0000;
                     rcnt_d      = '0;
                  end else begin
                     rcnt_d = rcnt_q + RCW'(1);
                  end
               end
               default: begin
                  rstate_d = R_IDLE;
                  rcnt_d   = '0;
               end
            endcase
         end
      end
   end

   // State registers; keys reset to the released (high) level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q       <= '1;
         sync2_q       <= '1;
         deb_q         <= '1;
         deb_prev_q    <= '1;
         ev_q          <= '0;
         for (int k = 0; k < NKEY; k++) dcnt_q[k] <= '0;
         adjust_mode_q <= M_IDLE;
         step_mode_q   <= 2'd0;
         rstate_q      <= R_IDLE;
         act_q         <= 2'd0;
         rcnt_q        <= '0;
         lim_pulse_q   <= 4'b0000;
         def_pulse_q   <= 1'b0;
      end else begin
         sync1_q       <= raw;
         sync2_q       <= sync1_q;
         deb_q         <= deb_d;
         deb_prev_q    <= deb_q;
         ev_q          <= ev_d;
         for (int k = 0; k < NKEY; k++) dcnt_q[k] <= dcnt_d[k];
         adjust_mode_q <= adjust_mode_d;
         step_mode_q   <= step_mode_d;
         rstate_q      <= rstate_d;
         act_q         <= act_d;
         rcnt_q        <= rcnt_d;
         lim_pulse_q   <= lim_pulse_d;
         def_pulse_q   <= def_pulse_d;
      end
   end

   assign adjust_mode       = adjust_mode_q;
   assign step_mode         = step_mode_q;
   assign btn_limit_dn_dn   = lim_pulse_q[0];
   assign btn_limit_dn_up   = lim_pulse_q[1];
   assign btn_limit_up_dn   = lim_pulse_q[2];
   assign btn_limit_up_up   = lim_pulse_q[3];
   assign btn_reset_default = def_pulse_q;

endmodule

// File: tb/tb_test_key_ctrl.sv
// Directed bench for test_key_ctrl with short debounce/repeat timing.
module tb_test_key_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       test_enable;
   logic       key_mode, key_step, key_dn_dn, key_dn_up, key_up_dn, key_up_up, key_default;
   logic [2:0] adjust_mode;
   logic [1:0] step_mode;
   logic       btn_limit_dn_dn, btn_limit_dn_up, btn_limit_up_dn, btn_limit_up_up;
   logic       btn_reset_default;

   int n_assert = 0;
   int n_fail   = 0;
   int t        = 0;
   int exp_step [4] = '{1, 2, 0, 1};

   logic [4:0] pv;
   assign pv = {btn_limit_dn_dn, btn_limit_dn_up, btn_limit_up_dn, btn_limit_up_up, btn_reset_default};

   test_key_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (5)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .test_enable      (test_enable),
      .key_mode         (key_mode),
      .key_step         (key_step),
      .key_dn_dn        (key_dn_dn),
      .key_dn_up        (key_dn_up),
      .key_up_dn        (key_up_dn),
      .key_up_up        (key_up_up),
      .key_default      (key_default),
      .adjust_mode      (adjust_mode),
      .step_mode        (step_mode),
      .btn_limit_dn_dn  (btn_limit_dn_dn),
      .btn_limit_dn_up  (btn_limit_dn_up),
      .btn_limit_up_dn  (btn_limit_up_dn),
      .btn_limit_up_up  (btn_limit_up_up),
      .btn_reset_default(btn_reset_default)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   // Advance to the next falling edge; t counts rising edges since the reference press
   task automatic tick();
      @(negedge clk);
      t++;
   endtask

   task automatic press_mode();
      key_mode = 1'b0;
      repeat (10) tick();
      key_mode = 1'b1;
      repeat (10) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; test_enable = 1'b0;
      key_mode = 1'b1; key_step = 1'b1; key_dn_dn = 1'b1; key_dn_up = 1'b1;
      key_up_dn = 1'b1; key_up_up = 1'b1; key_default = 1'b1;
      #12;
      check("rst_adjust", 32'(adjust_mode), 32'd0);
      check("rst_step",   32'(step_mode),   32'd0);
      check("rst_pulses", 32'(pv),          32'd0);

      @(negedge clk);
      rst_n = 1'b1; test_enable = 1'b1;
      repeat (3) tick();

      // Short glitch on key_mode is filtered
      key_mode = 1'b0;
      repeat (3) tick();
      key_mode = 1'b1;
      repeat (15) tick();
      check("glitch_adjust", 32'(adjust_mode), 32'd0);

      // Proper key_mode press advances IDLE -> FREQ at t=7
      key_mode = 1'b0; t = -1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (t == 6) check("mode_before", 32'(adjust_mode), 32'd0);
         if (t == 7) check("mode_after",  32'(adjust_mode), 32'd1);
         check("mode_nopulse", 32'(pv), 32'd0);
      end
      key_mode = 1'b1;
      repeat (12) tick();
      check("mode_hold", 32'(adjust_mode), 32'd1);

      // up_up held 40 cycles: 7, 27, 32, 37, 42
      key_up_up = 1'b0; t = -1;
      for (int i = 0; i < 60; i++) begin
         tick();
         check("upup_train", 32'(pv),
               32'({3'b000, (t == 7 || t == 27 || t == 32 || t == 37 || t == 42), 1'b0}));
         if (t == 39) key_up_up = 1'b1;
      end
      repeat (5) tick();

      // dn_up held, dn_dn pressed at t=30 takes over
      key_dn_up = 1'b0; t = -1;
      for (int i = 0; i < 82; i++) begin
         tick();
         check("takeover", 32'(pv),
               32'({(t == 37 || t == 57 || t == 62 || t == 67),
                    (t == 7 || t == 27 || t == 32), 3'b000}));
         if (t == 29) key_dn_dn = 1'b0;
         if (t == 64) begin
            key_dn_dn = 1'b1;
            key_dn_up = 1'b1;
         end
      end
      repeat (5) tick();

      // test_enable low: mode forced IDLE, step still advances, no commands
      test_enable = 1'b0;
      tick();
      check("te_off_adjust", 32'(adjust_mode), 32'd0);
      for (int p = 0; p < 4; p++) begin
         key_step = 1'b0; key_default = 1'b0; key_dn_dn = 1'b0;
         for (int i = 0; i < 10; i++) begin
            tick();
            check("te_off_nopulse", 32'(pv), 32'd0);
         end
         key_step = 1'b1; key_default = 1'b1; key_dn_dn = 1'b1;
         for (int i = 0; i < 10; i++) begin
            tick();
            check("te_off_nopulse", 32'(pv), 32'd0);
         end
         check("step_seq", 32'(step_mode), 32'(exp_step[p]));
         check("te_off_adjust", 32'(adjust_mode), 32'd0);
      end

      // Default key: one pulse at t=7, never repeated
      test_enable = 1'b1;
      tick();
      press_mode();
      check("freq_again", 32'(adjust_mode), 32'd1);
      key_default = 1'b0; t = -1;
      for (int i = 0; i < 30; i++) begin
         tick();
         check("default_once", 32'(pv), 32'({4'b0000, (t == 7)}));
      end
      key_default = 1'b1;
      repeat (10) tick();

      // THD mode, test_enable drops during repeat
      press_mode(); press_mode(); press_mode();
      check("thd_mode", 32'(adjust_mode), 32'd4);
      key_up_dn = 1'b0; t = -1;
      for (int i = 0; i < 46; i++) begin
         tick();
         check("te_drop", 32'(pv), 32'({2'b00, (t == 7 || t == 27 || t == 32), 2'b00}));
         if (t == 33) test_enable = 1'b0;
         if (t == 34) begin
            check("te_drop_adjust", 32'(adjust_mode), 32'd0);
            check("te_drop_fsm",    32'(dut.rstate_q), 32'd0);
         end
      end
      test_enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_held", 32'(pv), 32'd0);
      end
      key_up_dn = 1'b1;
      repeat (10) tick();

      // Reset mid-repeat with key held
      press_mode();
      check("pre_rst_adjust", 32'(adjust_mode), 32'd1);
      key_up_dn = 1'b0; t = -1;
      for (int i = 0; i < 33; i++) begin
         tick();
         check("pre_rst_train", 32'(pv), 32'({2'b00, (t == 7 || t == 27 || t == 32), 2'b00}));
      end
      rst_n = 1'b0;
      #1;
      check("async_rst_pulses", 32'(pv),          32'd0);
      check("async_rst_adjust", 32'(adjust_mode), 32'd0);
      check("async_rst_step",   32'(step_mode),   32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         check("post_rst_quiet", 32'(pv), 32'd0);
      end
      check("post_rst_adjust", 32'(adjust_mode), 32'd0);
      press_mode();
      check("post_rst_freq", 32'(adjust_mode), 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("held_no_event", 32'(pv), 32'd0);
      end
      key_up_dn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("release_quiet", 32'(pv), 32'd0);
      end
      key_up_dn = 1'b0; t = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("fresh_press", 32'(pv), 32'({2'b00, (t == 7), 2'b00}));
      end
      key_up_dn = 1'b1;
      repeat (12) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
